// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the data-cache port arbiter.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT
    } arb_state_t;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 32;

endpackage

// File: rtl/cache_port_arbiter_rr.sv
// Combinational round-robin pick: first set request at or above ptr, else lowest.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [N-1:0] mask;
    logic [N-1:0] hi;

    // Lowest-set-bit isolation on the masked vector avoids a variable index.
    always_comb begin
        mask = ~((N'(1) << ptr) - N'(1));
        hi   = req & mask;
        if (|hi) begin
            grant = hi & (~hi + N'(1));
        end else begin
            grant = req & (~req + N'(1));
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one data-cache request port between N_REQ requesters, round-robin,
// with a one-cycle issue strobe and a one-cycle ack on completion.
module cache_port_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = cache_arb_pkg::ADDR_W,
    parameter int DATA_W = cache_arb_pkg::DATA_W
) (
    input  logic                      clock,
    input  logic                      cpu_reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wd,
    output logic [N_REQ-1:0]          req_ack,
    output logic [DATA_W-1:0]         req_rd,
    output logic                      cache_en,
    output logic                      cache_we,
    output logic [ADDR_W-1:0]         cache_addr,
    output logic [DATA_W-1:0]         cache_wd,
    input  logic [DATA_W-1:0]         cache_rd,
    input  logic                      cache_stall,
    output logic                      busy
);

    import cache_arb_pkg::*;

    localparam int PW = $clog2(N_REQ);

    arb_state_t          state_q, state_d;
    logic [N_REQ-1:0]    grant_q;
    logic [N_REQ-1:0]    gnt;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       gidx;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wd_q, wd_d;
    logic [DATA_W-1:0]   rd_q;
    logic                launch;
    logic                done;

    rr_arbiter #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr (
        .req   (req),
        .ptr   (ptr_q),
        .grant (gnt)
    );

    assign launch = (state_q == ARB_IDLE) && (|req) && !cache_stall;
    assign done   = (state_q == ARB_WAIT) && !cache_stall;

    always_ff @(posedge clock) begin
        if (cpu_reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE:  if (launch) state_d = ARB_ISSUE;
            ARB_ISSUE: state_d = ARB_WAIT;
            ARB_WAIT:  if (done) state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        gidx   = '0;
        we_d   = 1'b0;
        addr_d = '0;
        wd_d   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                gidx   = PW'(i);
                we_d   = req_we[i];
                addr_d = req_addr[i*ADDR_W +: ADDR_W];
                wd_d   = req_wd[i*DATA_W +: DATA_W];
            end
        end
        ptr_d = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + PW'(1);
    end

    always_ff @(posedge clock) begin
        if (cpu_reset) begin
            grant_q <= '0;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
        end else begin
            if (launch) begin
                grant_q <= gnt;
                ptr_q   <= ptr_d;
                we_q    <= we_d;
                addr_q  <= addr_d;
                wd_q    <= wd_d;
            end
            if (done) begin
                rd_q <= cache_rd;
            end
        end
    end

    // Ack is suppressed while reset is asserted so an aborted op never completes.
    always_comb begin
        cache_en = (state_q == ARB_ISSUE);
        busy     = (state_q != ARB_IDLE);
        req_ack  = (done && !cpu_reset) ? grant_q : '0;
        req_rd   = (done && !cpu_reset) ? cache_rd : rd_q;
    end

    assign cache_we   = we_q;
    assign cache_addr = addr_q;
    assign cache_wd   = wd_q;

endmodule
